aes_block_gearbox: RTL and testbench

Parametrised streaming converter between narrow lane streams and 128-bit AES state blocks, with valid/ready handshakes on every side.
- Pack path: assembles 128/LANE_W lanes into one block.
- Unpack path: emits one block as 128/LANE_W lanes.
- Optional byte transpose selects column-major (AES state order) or row-major stream order.
- Sits between byte/word I/O interfaces and the round datapath.

---
 rtl/aes_block_gearbox_pkg.sv | 22 ++
 rtl/aes_block_gearbox_if.sv | 33 +++
 rtl/aes_byte_transpose.sv | 16 +
 rtl/aes_block_gearbox.sv | 150 +++++++++++++++
 tb/tb_aes_block_gearbox.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_block_gearbox_pkg.sv
// rtl/aes_block_gearbox_pkg.sv - shared constants, types and index helpers for the AES block gearbox
package aes_gearbox_pkg;

  localparam int BLK_W = 128;
  localparam int BYTES = 16;

  typedef enum logic {
    UP_IDLE = 1'b0,
    UP_BUSY = 1'b1
  } up_state_e;

  // Byte index i of one order maps to byte xpose_idx(i) of the other; self-inverse.
  function automatic int xpose_idx(input int i);
    return 4 * (i % 4) + i / 4;
  endfunction

  // Number of lanes that make up one 128-bit block.
  function automatic int lane_count(input int lane_w);
    return BLK_W / lane_w;
  endfunction

endpackage

// File: rtl/aes_block_gearbox_if.sv
// rtl/aes_block_gearbox_if.sv - lane and block handshake bundle for the AES block gearbox
interface aes_block_gearbox_if #(
  parameter int LANE_W = 8
);

  logic                               pk_in_valid;
  logic                               pk_in_ready;
  logic [LANE_W-1:0]                  pk_in_data;
  logic                               pk_blk_valid;
  logic                               pk_blk_ready;
  logic [aes_gearbox_pkg::BLK_W-1:0]  pk_blk_data;
  logic                               up_blk_valid;
  logic                               up_blk_ready;
  logic [aes_gearbox_pkg::BLK_W-1:0]  up_blk_data;
  logic                               up_out_valid;
  logic                               up_out_ready;
  logic [LANE_W-1:0]                  up_out_data;

  modport slave (
    input  pk_in_valid, pk_in_data, pk_blk_ready,
    input  up_blk_valid, up_blk_data, up_out_ready,
    output pk_in_ready, pk_blk_valid, pk_blk_data,
    output up_blk_ready, up_out_valid, up_out_data
  );

  modport master (
    output pk_in_valid, pk_in_data, pk_blk_ready,
    output up_blk_valid, up_blk_data, up_out_ready,
    input  pk_in_ready, pk_blk_valid, pk_blk_data,
    input  up_blk_ready, up_out_valid, up_out_data
  );

endinterface

// File: rtl/aes_byte_transpose.sv
// rtl/aes_byte_transpose.sv - combinational row/column byte transpose of a 128-bit block
module aes_byte_transpose
  import aes_gearbox_pkg::*;
(
  input  logic             en_i,
  input  logic [BLK_W-1:0] data_i,
  output logic [BLK_W-1:0] data_o
);

  for (genvar j = 0; j < BYTES; j++) begin : g_byte
    localparam int SRC = xpose_idx(j);
    assign data_o[BLK_W-1-8*j -: 8] = en_i ? data_i[BLK_W-1-8*SRC -: 8]
                                           : data_i[BLK_W-1-8*j -: 8];
  end

endmodule

// File: rtl/aes_block_gearbox.sv
// rtl/aes_block_gearbox.sv - lane <-> 128-bit block gearbox; optional AES_GEARBOX_FLUSH_EN adds a flush input
module aes_block_gearbox
  import aes_gearbox_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int ORDER  = 0
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AES_GEARBOX_FLUSH_EN
  input  logic                flush,
`endif
  aes_block_gearbox_if.slave  bus
);

  localparam int               N        = lane_count(LANE_W);
  localparam int               CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Flush clears both paths exactly like reset; any same-cycle transfer is dropped.
  logic clr;
`ifdef AES_GEARBOX_FLUSH_EN
  assign clr = rst | flush;
`else
  assign clr = rst;
`endif

  // ---------------- pack path ----------------
  logic [CNT_W-1:0] pk_cnt_q, pk_cnt_d;
  logic [BLK_W-1:0] pk_sr_q, pk_sr_d;
  logic [BLK_W-1:0] pk_blk_q, pk_blk_d;
  logic             pk_vld_q, pk_vld_d;
  logic [BLK_W-1:0] pk_asm, pk_asm_x;
  logic             pk_in_fire, pk_last;

  // Only the final beat can stall, and only while a held block is not leaving.
  assign bus.pk_in_ready  = (pk_cnt_q != CNT_LAST) || !pk_vld_q || bus.pk_blk_ready;
  assign pk_in_fire       = bus.pk_in_valid && bus.pk_in_ready;
  assign pk_last          = pk_in_fire && (pk_cnt_q == CNT_LAST);
  assign pk_asm           = {pk_sr_q[BLK_W-LANE_W-1:0], bus.pk_in_data};
  assign bus.pk_blk_valid = pk_vld_q;
  assign bus.pk_blk_data  = pk_blk_q;

  aes_byte_transpose u_pk_xpose (
    .en_i   (ORDER != 0),
    .data_i (pk_asm),
    .data_o (pk_asm_x)
  );

  // Shift lanes in MSB-first; completed block replaces the held one on the last beat.
  always_comb begin
    pk_cnt_d = pk_cnt_q;
    pk_sr_d  = pk_sr_q;
    pk_blk_d = pk_blk_q;
    pk_vld_d = pk_vld_q;
    if (pk_in_fire) begin
      pk_cnt_d = pk_cnt_q + 1'b1;
      pk_sr_d  = pk_asm;
    end
    if (pk_last) begin
      pk_blk_d = pk_asm_x;
      pk_vld_d = 1'b1;
    end else if (bus.pk_blk_ready) begin
      pk_vld_d = 1'b0;
    end
  end

  // Pack path registers; a reset mid-block discards the partial assembly.
  always_ff @(posedge clk) begin
    if (clr) begin
      pk_cnt_q <= '0;
      pk_sr_q  <= '0;
      pk_blk_q <= '0;
      pk_vld_q <= 1'b0;
    end else begin
      pk_cnt_q <= pk_cnt_d;
      pk_sr_q  <= pk_sr_d;
      pk_blk_q <= pk_blk_d;
      pk_vld_q <= pk_vld_d;
    end
  end

  // ---------------- unpack path ----------------
  up_state_e        up_st_q, up_st_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [BLK_W-1:0] up_sr_q, up_sr_d;
  logic [BLK_W-1:0] up_blk_x;
  logic             up_blk_fire, up_lane_fire, up_lane_last;

  assign up_lane_fire    = bus.up_out_valid && bus.up_out_ready;
  assign up_lane_last    = up_lane_fire && (up_cnt_q == CNT_LAST);
  assign up_blk_fire     = bus.up_blk_valid && bus.up_blk_ready;
  assign bus.up_out_data = up_sr_q[BLK_W-1 -: LANE_W];

  aes_byte_transpose u_up_xpose (
    .en_i   (ORDER != 0),
    .data_i (bus.up_blk_data),
    .data_o (up_blk_x)
  );

  // Unpack state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      up_st_q <= UP_IDLE;
    end else begin
      up_st_q <= up_st_d;
    end
  end

  // Stay busy across a block boundary when the next block arrives with the last lane.
  always_comb begin
    up_st_d = up_st_q;
    case (up_st_q)
      UP_IDLE: if (up_blk_fire) up_st_d = UP_BUSY;
      UP_BUSY: if (up_lane_last && !up_blk_fire) up_st_d = UP_IDLE;
      default: up_st_d = UP_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; a new block is taken only as the last lane drains.
  always_comb begin
    bus.up_out_valid = (up_st_q == UP_BUSY);
    bus.up_blk_ready = (up_st_q != UP_BUSY) || ((up_cnt_q == CNT_LAST) && bus.up_out_ready);
  end

  // Load a fresh block or shift out one lane per accepted beat.
  always_comb begin
    up_sr_d  = up_sr_q;
    up_cnt_d = up_cnt_q;
    if (up_blk_fire) begin
      up_sr_d  = up_blk_x;
      up_cnt_d = '0;
    end else if (up_lane_fire) begin
      up_sr_d  = up_sr_q << LANE_W;
      up_cnt_d = up_cnt_q + 1'b1;
    end
  end

  // Unpack datapath registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      up_sr_q  <= '0;
      up_cnt_q <= '0;
    end else begin
      up_sr_q  <= up_sr_d;
      up_cnt_q <= up_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_block_gearbox.sv
// tb/tb_aes_block_gearbox.sv - self-checking bench for aes_block_gearbox across lane widths and orders
module tb_aes_block_gearbox;

  localparam int NI = 5;
  localparam int LWS  [NI] = '{8, 8, 32, 16, 64};
  localparam int ORDS [NI] = '{0, 1, 0, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr_tb;
`ifdef AES_GEARBOX_FLUSH_EN
  logic flush;
  assign clr_tb = rst | flush;
`else
  assign clr_tb = rst;
`endif

  logic         pkv [NI], pbr [NI], ubv [NI], uor [NI];
  logic [63:0]  pkd [NI];
  logic [127:0] ubd [NI];
  logic         pkr [NI], pbv [NI], ubr [NI], uov [NI];
  logic [127:0] pbd [NI];
  logic [63:0]  uod [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_block_gearbox_if #(.LANE_W(LWS[g])) bus ();
    aes_block_gearbox #(.LANE_W(LWS[g]), .ORDER(ORDS[g])) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef AES_GEARBOX_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus.slave)
    );
    assign bus.pk_in_valid  = pkv[g];
    assign bus.pk_in_data   = pkd[g][LWS[g]-1:0];
    assign bus.pk_blk_ready = pbr[g];
    assign bus.up_blk_valid = ubv[g];
    assign bus.up_blk_data  = ubd[g];
    assign bus.up_out_ready = uor[g];
    assign pkr[g] = bus.pk_in_ready;
    assign pbv[g] = bus.pk_blk_valid;
    assign pbd[g] = bus.pk_blk_data;
    assign ubr[g] = bus.up_blk_ready;
    assign uov[g] = bus.up_out_valid;
    assign uod[g] = 64'(bus.up_out_data);
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  logic [7:0]   pk_q   [NI][$];
  logic [127:0] pkb_q  [NI][$];
  logic [7:0]   up_q   [NI][$];
  logic [127:0] pk_log [NI][$];
  logic [63:0]  up_log [NI][$];
  int           uv_first [NI];
  int           uv_last  [NI];

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
    end
  endtask

  // Stream byte k sits at state row k%4/col k/4 (ORDER=0) or row k/4/col k%4 (ORDER=1); block byte = 4*col+row.
  function automatic int spos(input int k, input int o);
    int r, c;
    if (o == 0) begin r = k % 4; c = k / 4; end
    else        begin r = k / 4; c = k % 4; end
    return 4 * c + r;
  endfunction

  // Reference model and per-cycle comparison for all instances.
  always @(negedge clk) begin
    int bpl, j;
    logic [127:0] blk;
    logic [63:0] ln;
    logic exp_pr, exp_ur;
    cyc++;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        bpl    = LWS[i] / 8;
        exp_pr = (pk_q[i].size() != 16 - bpl) || (pkb_q[i].size() == 0) || pbr[i];
        exp_ur = (up_q[i].size() == 0) || ((up_q[i].size() == bpl) && uor[i]);
        chk("pk_blk_valid", i, 128'(pbv[i]), 128'(pkb_q[i].size() > 0));
        if (pkb_q[i].size() > 0) chk("pk_blk_data", i, pbd[i], pkb_q[i][0]);
        chk("pk_in_ready", i, 128'(pkr[i]), 128'(exp_pr));
        chk("up_out_valid", i, 128'(uov[i]), 128'(up_q[i].size() > 0));
        if (up_q[i].size() > 0) begin
          ln = '0;
          for (int b = 0; b < bpl; b++) ln = {ln[55:0], up_q[i][b]};
          chk("up_out_data", i, 128'(uod[i]), 128'(ln));
        end
        chk("up_blk_ready", i, 128'(ubr[i]), 128'(exp_ur));
        if (uov[i]) begin
          if (uv_first[i] < 0) uv_first[i] = cyc;
          uv_last[i] = cyc;
        end
        if (clr_tb) begin
          pk_q[i].delete(); pkb_q[i].delete(); up_q[i].delete();
        end else begin
          if (pkb_q[i].size() > 0 && pbr[i]) pk_log[i].push_back(pkb_q[i].pop_front());
          if (pkv[i] && exp_pr) begin
            for (int b = 0; b < bpl; b++) pk_q[i].push_back(pkd[i][LWS[i]-1-8*b -: 8]);
            if (pk_q[i].size() == 16) begin
              blk = '0;
              for (int k = 0; k < 16; k++) begin
                j = spos(k, ORDS[i]);
                blk[127-8*j -: 8] = pk_q[i][k];
              end
              pkb_q[i].push_back(blk);
              pk_q[i].delete();
            end
          end
          if (up_q[i].size() > 0 && uor[i]) begin
            ln = '0;
            for (int b = 0; b < bpl; b++) ln = {ln[55:0], up_q[i].pop_front()};
            up_log[i].push_back(ln);
          end
          if (ubv[i] && exp_ur) begin
            for (int k = 0; k < 16; k++) begin
              j = spos(k, ORDS[i]);
              up_q[i].push_back(ubd[i][127-8*j -: 8]);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lane(input int i, input logic [63:0] d, output int waits);
    logic ok;
    pkv[i] = 1'b1;
    pkd[i] = d;
    waits  = 0;
    ok     = 1'b0;
    while (!ok && waits < 64) begin
      @(negedge clk);
      ok = pkr[i];
      tick();
      waits++;
    end
    if (!ok) chk("push_lane_timeout", i, 128'(ok), 128'(1));
  endtask

  task automatic push_blk(input int i, input logic [127:0] d, output int waits);
    logic ok;
    ubv[i] = 1'b1;
    ubd[i] = d;
    waits  = 0;
    ok     = 1'b0;
    while (!ok && waits < 64) begin
      @(negedge clk);
      ok = ubr[i];
      tick();
      waits++;
    end
    if (!ok) chk("push_blk_timeout", i, 128'(ok), 128'(1));
  endtask

  function automatic logic [63:0] lane32(input int n);
    logic [63:0] d;
    d = '0;
    for (int b = 0; b < 4; b++) d = {d[55:0], 8'(4 * n + b)};
    return d;
  endfunction

  localparam logic [127:0] B1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B2 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] B3 = 128'hDEADBEEF0123456789ABCDEFF00DCAFE;

  initial begin
    int w, tot, stalled, n, c;
    logic [127:0] blks [3];
    blks[0] = B1; blks[1] = B2; blks[2] = B3;
    rst = 1'b1;
`ifdef AES_GEARBOX_FLUSH_EN
    flush = 1'b0;
`endif
    for (int i = 0; i < NI; i++) begin
      pkv[i] = 1'b0; pkd[i] = '0; pbr[i] = 1'b1;
      ubv[i] = 1'b0; ubd[i] = '0; uor[i] = 1'b1;
      uv_first[i] = -1; uv_last[i] = -1;
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_pk_blk_valid", i, 128'(pbv[i]), 128'(0));
      chk("rst_pk_blk_data",  i, pbd[i], 128'(0));
      chk("rst_up_out_valid", i, 128'(uov[i]), 128'(0));
      chk("rst_up_out_data",  i, 128'(uod[i]), 128'(0));
    end
    chk_en = 1'b1;
    tick();

    // Byte stream, column-major, no backpressure.
    tot = 0;
    for (int k = 0; k < 16; k++) begin push_lane(0, 64'(k), w); tot += w; end
    pkv[0] = 1'b0;
    chk("t1_no_stall", 0, 128'(tot), 128'(16));
    @(negedge clk);
    chk("t1_latency", 0, 128'(pbv[0]), 128'(1));
    repeat (3) tick();
    chk("t1_count", 0, 128'(pk_log[0].size()), 128'(1));
    if (pk_log[0].size() > 0) chk("t1_block", 0, pk_log[0][0], B1);

    // Same stream, row-major.
    for (int k = 0; k < 16; k++) push_lane(1, 64'(k), w);
    pkv[1] = 1'b0;
    repeat (3) tick();
    chk("t2_count", 1, 128'(pk_log[1].size()), 128'(1));
    if (pk_log[1].size() > 0) chk("t2_block", 1, pk_log[1][0], 128'h0004080C0105090D02060A0E03070B0F);

    // 32-bit lanes under block backpressure.
    pbr[2] = 1'b0;
    tot = 0;
    for (int k = 0; k < 7; k++) begin push_lane(2, lane32(k), w); tot += w; end
    chk("t3_no_stall", 2, 128'(tot), 128'(7));
    pkv[2] = 1'b1;
    pkd[2] = lane32(7);
    stalled = 0;
    repeat (4) begin
      @(negedge clk);
      if (!pkr[2]) stalled++;
      tick();
    end
    chk("t3_stall", 2, 128'(stalled), 128'(4));
    chk("t3_held", 2, 128'(pk_log[2].size()), 128'(0));
    pbr[2] = 1'b1;
    push_lane(2, lane32(7), w);
    chk("t3_release", 2, 128'(w), 128'(1));
    pkv[2] = 1'b0;
    repeat (3) tick();
    chk("t3_count", 2, 128'(pk_log[2].size()), 128'(2));
    if (pk_log[2].size() == 2) begin
      chk("t3_block1", 2, pk_log[2][0], B1);
      chk("t3_block2", 2, pk_log[2][1], B2);
    end

    // 16-bit unpack, two blocks back-to-back.
    push_blk(3, B1, w);
    push_blk(3, B2, w);
    chk("t4_second_wait", 3, 128'(w), 128'(8));
    ubv[3] = 1'b0;
    repeat (12) tick();
    chk("t4_count", 3, 128'(up_log[3].size()), 128'(16));
    chk("t4_contig", 3, 128'(uv_last[3] - uv_first[3] + 1), 128'(16));
    if (up_log[3].size() == 16) begin
      chk("t4_lane0", 3, 128'(up_log[3][0]), 128'(16'h0001));
      chk("t4_lane8", 3, 128'(up_log[3][8]), 128'(16'h1011));
    end

    // 64-bit row-major unpack with random output backpressure.
    n = 0;
    c = 0;
    while (c < 300 && (n < 3 || up_q[4].size() > 0)) begin
      uor[4] = 1'($urandom_range(0, 1));
      ubv[4] = (n < 3);
      if (n < 3) ubd[4] = blks[n];
      @(negedge clk);
      if (ubv[4] && ubr[4]) n++;
      tick();
      c++;
    end
    ubv[4] = 1'b0;
    uor[4] = 1'b1;
    repeat (2) tick();
    chk("t5_finished", 4, 128'(c < 300), 128'(1));
    chk("t5_count", 4, 128'(up_log[4].size()), 128'(6));
    if (up_log[4].size() == 6) begin
      chk("t5_lane0", 4, 128'(up_log[4][0]), 128'(64'h0004080C0105090D));
      chk("t5_lane1", 4, 128'(up_log[4][1]), 128'(64'h02060A0E03070B0F));
    end

    // Reset after 5 of 16 beats leaves no residue.
    for (int k = 0; k < 5; k++) push_lane(0, 64'(8'hA0 + k), w);
    pkv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) push_lane(0, 64'(8'h10 + k), w);
    pkv[0] = 1'b0;
    repeat (3) tick();
    chk("t6_count", 0, 128'(pk_log[0].size()), 128'(2));
    if (pk_log[0].size() == 2) chk("t6_block", 0, pk_log[0][1], B2);

`ifdef AES_GEARBOX_FLUSH_EN
    // Flush after 5 of 16 beats, row-major instance.
    for (int k = 0; k < 5; k++) push_lane(1, 64'(8'hA0 + k), w);
    pkv[1] = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 16; k++) push_lane(1, 64'(8'h10 + k), w);
    pkv[1] = 1'b0;
    repeat (3) tick();
    chk("t7_count", 1, 128'(pk_log[1].size()), 128'(2));
    if (pk_log[1].size() == 2) chk("t7_block", 1, pk_log[1][1], 128'h1014181C1115191D12161A1E13171B1F);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
